// File: rtl/mem_xfer_engine.sv
// Bus-initiator block copier: reads bytes from a source range, optionally transforms
// them, and writes them to a destination range, one read/write pair per byte.
module mem_xfer_engine #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    input  logic [1:0]        op,
    input  logic [7:0]        key,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    output logic              wboolean,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [7:0]        byte_q, byte_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        op_q, op_d;
    logic [7:0]        key_q, key_d;

    logic [7:0]        rbyte;
    logic [7:0]        xbyte;
    logic [ADDR_W-1:0] idx_ext;

    // Only the low byte of the read bus carries payload.
    logic unused_rdata;
    assign unused_rdata = ^rdata[DATA_W-1:8];

    assign rbyte   = rdata[7:0];
    assign idx_ext = ADDR_W'(idx_q);

    always_comb begin
        xbyte = rbyte;
        unique case (op_q)
            2'b00: xbyte = rbyte;
            2'b01: xbyte = ~rbyte;
            2'b10: xbyte = rbyte ^ key_q;
            2'b11: xbyte = rbyte + key_q;
            default: xbyte = rbyte;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        op_d    = op_q;
        key_d   = key_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    len_d   = length;
                    op_d    = op;
                    key_d   = key;
                    idx_d   = '0;
                    state_d = (length == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (bus_gnt) begin
                    byte_d  = xbyte;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (bus_gnt) begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = (idx_d == len_q) ? StDone : StRead;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            byte_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            op_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            op_q    <= op_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        bus_req  = 1'b0;
        address  = '0;
        wdata    = '0;
        wboolean = 1'b0;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        unique case (state_q)
            StRead: begin
                bus_req = 1'b1;
                address = src_q + idx_ext;
            end
            StWrite: begin
                bus_req  = 1'b1;
                address  = dst_q + idx_ext;
                wdata    = DATA_W'(byte_q);
                wboolean = bus_gnt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Bench for mem_xfer_engine: bus memory model, progress-count reference model checked
// every cycle, and directed transfers with hand-computed results.
module tb_mem_xfer_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_base = '0;
    logic [31:0] dst_base = '0;
    logic [8:0]  length = '0;
    logic [1:0]  op = '0;
    logic [7:0]  key = '0;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        wboolean;
    logic [31:0] rdata;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    mem_xfer_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
        .length(length), .op(op), .key(key), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .address(address), .wdata(wdata), .wboolean(wboolean), .rdata(rdata),
        .busy(busy), .done(done)
    );

    // 512-byte memory; preload port is used only while the engine is idle.
    logic [7:0] mem [512];
    logic       pl_en = 1'b0;
    logic [8:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    assign rdata = (address < 32'd512) ? {24'b0, mem[address[8:0]]} : 32'b0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (wboolean && address < 32'd512) mem[address[8:0]] <= wdata[7:0];
    end

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] f(input logic [1:0] o, input logic [7:0] k,
                                     input logic [7:0] x);
        case (o)
            2'b00: return x;
            2'b01: return ~x;
            2'b10: return x ^ k;
            default: return x + k;
        endcase
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return (a < 32'd512) ? mem[a[8:0]] : 8'h00;
    endfunction

    // Model: a transfer of N bytes is 2N granted bus steps followed by one done cycle.
    // Step p reads byte p/2 when p is even and writes it when p is odd.
    bit          m_act = 1'b0;
    int          m_p = 0;
    int          m_n = 0;
    logic [31:0] m_src = '0;
    logic [31:0] m_dst = '0;
    logic [1:0]  m_op = '0;
    logic [7:0]  m_key = '0;
    logic [7:0]  m_byte = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 1'b0;
            m_p   <= 0;
        end else if (!m_act) begin
            if (start) begin
                m_act <= 1'b1;
                m_p   <= 0;
                m_n   <= int'(length);
                m_src <= src_base;
                m_dst <= dst_base;
                m_op  <= op;
                m_key <= key;
            end
        end else if (m_p == 2 * m_n) begin
            m_act <= 1'b0;
        end else if (bus_gnt) begin
            m_p <= m_p + 1;
            if (m_p % 2 == 0) m_byte <= f(m_op, m_key, mem_rd(m_src + 32'(m_p / 2)));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_req, e_done, e_wr;
            logic [31:0] e_addr;
            e_req  = m_act && (m_p < 2 * m_n);
            e_done = m_act && (m_p == 2 * m_n);
            e_wr   = e_req && (m_p % 2 == 1);
            e_addr = !e_req ? 32'h0 :
                     (e_wr ? m_dst + 32'(m_p / 2) : m_src + 32'(m_p / 2));
            chk("busy", 32'(busy), 32'(m_act));
            chk("done", 32'(done), 32'(e_done));
            chk("bus_req", 32'(bus_req), 32'(e_req));
            chk("address", address, e_addr);
            chk("wboolean", 32'(wboolean), 32'(e_wr && bus_gnt));
            chk("wdata", wdata, e_wr ? {24'b0, m_byte} : 32'h0);
        end
    end

    int done_at, wr_cnt, req_cnt, busy_cnt;

    task automatic preload(input logic [8:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk); #2;
        pl_en = 1'b0;
    endtask

    // Entered and left at 2 time units after a rising edge.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [8:0] n,
                       input logic [1:0] o, input logic [7:0] k, input int stall_c,
                       input int stall_n, input int rst_c, input int restart_c);
        int c;
        bit fin;
        done_at = -1; wr_cnt = 0; req_cnt = 0; busy_cnt = 0;
        src_base = s; dst_base = d; length = n; op = o; key = k;
        start = 1'b1; bus_gnt = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        dst_base = 32'h1F0;
        length = 9'd7;
        c = 1;
        fin = 1'b0;
        while (!fin && c < 200) begin
            bus_gnt  = !(c >= stall_c && c < stall_c + stall_n);
            rst      = (c == rst_c);
            start    = (c == restart_c);
            src_base = (c == restart_c) ? 32'h30 : 32'h1F0;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (bus_req) req_cnt++;
            if (wboolean) wr_cnt++;
            if (done) begin
                done_at = c;
                fin = 1'b1;
            end
            @(posedge clk); #2;
            if (c == rst_c) fin = 1'b1;
            c++;
        end
        chk("no_timeout", 32'(c < 200), 32'd1);
        rst = 1'b0; start = 1'b0; bus_gnt = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", address, 32'd0);
        @(posedge clk); #2;

        preload(9'h010, 8'h11); preload(9'h011, 8'h22);
        preload(9'h012, 8'h33); preload(9'h013, 8'h44);
        preload(9'h020, 8'hF0);
        for (int i = 0; i < 8; i++) preload(9'h040 + 9'(i), 8'(i + 1));
        for (int i = 0; i < 8; i++) preload(9'h180 + 9'(i), 8'hEE);
        for (int i = 0; i < 20; i++) preload(9'h100 + 9'(i), 8'h00);

        // Plain copy.
        run(32'h010, 32'h100, 9'd4, 2'b00, 8'h00, 0, 0, -1, -1);
        chk("copy_b0", 32'(mem[9'h100]), 32'h11);
        chk("copy_b1", 32'(mem[9'h101]), 32'h22);
        chk("copy_b2", 32'(mem[9'h102]), 32'h33);
        chk("copy_b3", 32'(mem[9'h103]), 32'h44);
        chk("copy_writes", 32'(wr_cnt), 32'd4);
        chk("copy_done_cyc", 32'(done_at), 32'd9);
        chk("copy_busy_cyc", 32'(busy_cnt), 32'd9);

        // XOR key, started in the idle cycle right after the previous DONE.
        run(32'h010, 32'h100, 9'd4, 2'b10, 8'hA5, 0, 0, -1, -1);
        chk("xor_b0", 32'(mem[9'h100]), 32'hB4);
        chk("xor_b1", 32'(mem[9'h101]), 32'h87);
        chk("xor_b2", 32'(mem[9'h102]), 32'h96);
        chk("xor_b3", 32'(mem[9'h103]), 32'hE1);

        // ADD with carry dropped.
        run(32'h020, 32'h104, 9'd1, 2'b11, 8'h20, 0, 0, -1, -1);
        chk("add_b0", 32'(mem[9'h104]), 32'h10);
        chk("add_done_cyc", 32'(done_at), 32'd3);

        // Zero length.
        run(32'h010, 32'h105, 9'd0, 2'b00, 8'h00, 0, 0, -1, -1);
        chk("len0_done_cyc", 32'(done_at), 32'd1);
        chk("len0_writes", 32'(wr_cnt), 32'd0);
        chk("len0_req_cyc", 32'(req_cnt), 32'd0);
        chk("len0_busy_cyc", 32'(busy_cnt), 32'd1);
        chk("len0_untouched", 32'(mem[9'h105]), 32'h00);

        // Grant withheld for three cycles during the second write.
        run(32'h010, 32'h108, 9'd3, 2'b01, 8'h00, 4, 3, -1, -1);
        chk("stall_b0", 32'(mem[9'h108]), 32'hEE);
        chk("stall_b1", 32'(mem[9'h109]), 32'hDD);
        chk("stall_b2", 32'(mem[9'h10A]), 32'hCC);
        chk("stall_writes", 32'(wr_cnt), 32'd3);
        chk("stall_done_cyc", 32'(done_at), 32'd10);

        // Reset in the cycle after the second write of an 8-byte transfer.
        run(32'h040, 32'h180, 9'd8, 2'b00, 8'h00, 0, 0, 5, -1);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_we", 32'(wboolean), 32'd0);
        @(posedge clk); #2;
        chk("rst_b0", 32'(mem[9'h180]), 32'h01);
        chk("rst_b1", 32'(mem[9'h181]), 32'h02);
        for (int i = 2; i < 8; i++) chk("rst_untouched", 32'(mem[9'h180 + 9'(i)]), 32'hEE);

        run(32'h040, 32'h180, 9'd8, 2'b00, 8'h00, 0, 0, -1, -1);
        chk("rerun_done_cyc", 32'(done_at), 32'd17);
        chk("rerun_b7", 32'(mem[9'h187]), 32'h08);
        chk("rerun_writes", 32'(wr_cnt), 32'd8);

        // Start pulsed mid-transfer with another source is ignored.
        run(32'h010, 32'h110, 9'd4, 2'b00, 8'h00, 0, 0, -1, 3);
        chk("restart_b0", 32'(mem[9'h110]), 32'h11);
        chk("restart_b3", 32'(mem[9'h113]), 32'h44);
        chk("restart_done_cyc", 32'(done_at), 32'd9);
        @(negedge clk);
        chk("restart_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
